// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multi-cycle MIPS-subset datapath.
// Define MCFSM_ADDI_EN to decode opcode 001000 (ADDI).
module multicycle_control_fsm (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pcwrite,
    output logic       pcwritecond,
    output logic       iord,
    output logic       memread,
    output logic       memwrite,
    output logic       irwrite,
    output logic       memtoreg,
    output logic       regdist,
    output logic       regwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] aluop,
    output logic [1:0] pcsource,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        JUMP   = 4'd9,
        ADDIEX = 4'd10,
        ADDIWB = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t cur;
    state_t nxt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cur <= FETCH;
        else
            cur <= nxt;
    end

    assign state = cur;

    always_comb begin
        nxt         = FETCH;
        pcwrite     = 1'b0;
        pcwritecond = 1'b0;
        iord        = 1'b0;
        memread     = 1'b0;
        memwrite    = 1'b0;
        irwrite     = 1'b0;
        memtoreg    = 1'b0;
        regdist     = 1'b0;
        regwrite    = 1'b0;
        alusrca     = 1'b0;
        alusrcb     = 2'b00;
        aluop       = 2'b00;
        pcsource    = 2'b00;
        illegal_op  = 1'b0;
        case (cur)
            FETCH: begin
                memread = 1'b1;
                alusrcb = 2'b01;
                irwrite = mem_ready;
                pcwrite = mem_ready;
                nxt     = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (opcode)
                    OP_RTYPE: nxt = EXEC;
                    OP_LW:    nxt = MEMADR;
                    OP_SW:    nxt = MEMADR;
                    OP_BEQ:   nxt = BRANCH;
                    OP_J:     nxt = JUMP;
`ifdef MCFSM_ADDI_EN
                    OP_ADDI:  nxt = ADDIEX;
`endif
                    default: begin
                        nxt        = FETCH;
                        illegal_op = 1'b1;
                    end
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                if (opcode == OP_LW)
                    nxt = MEMRD;
                else if (opcode == OP_SW)
                    nxt = MEMWR;
            end
            MEMRD: begin
                memread = 1'b1;
                iord    = 1'b1;
                nxt     = mem_ready ? MEMWB : MEMRD;
            end
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                memwrite = 1'b1;
                iord     = 1'b1;
                nxt      = mem_ready ? FETCH : MEMWR;
            end
            EXEC: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nxt     = ALUWB;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdist  = 1'b1;
            end
            BRANCH: begin
                alusrca     = 1'b1;
                aluop       = 2'b01;
                pcwritecond = 1'b1;
                pcsource    = 2'b01;
            end
            JUMP: begin
                pcwrite  = 1'b1;
                pcsource = 2'b10;
            end
`ifdef MCFSM_ADDI_EN
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nxt     = ADDIWB;
            end
            ADDIWB: begin
                regwrite = 1'b1;
            end
`endif
            // Unused encodings fall back to FETCH with all outputs low.
            default: nxt = FETCH;
        endcase
    end

endmodule

// File: doc/multicycle_control_fsm.md
# multicycle_control_fsm

Sequencing controller for the multi-cycle variant of the MIPS-subset processor. It replaces the single-cycle opcode decoder with a Moore state machine that steps one shared ALU and one unified instruction/data memory through the phases of each instruction: fetch, decode, execute, memory and writeback. It asserts per-phase datapath enables and mux selects, and it stalls on a memory-ready handshake.

## Interface
- No parameters.
- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-high; forces state FETCH.
- `opcode` input 6: instr[31:26] from the external instruction register; sampled only in DECODE and MEMADR.
- `mem_ready` input 1: memory completes the current access this cycle.
- `pcwrite` output 1: unconditional PC load.
- `pcwritecond` output 1: PC load qualified by ALU zero.
- `iord` output 1: memory address select; 0=PC, 1=ALUOut.
- `memread` output 1: memory read request.
- `memwrite` output 1: memory write request.
- `irwrite` output 1: instruction register load.
- `memtoreg` output 1: writeback data select; 1=memory data register.
- `regdist` output 1: destination register select; 1=rd, 0=rt.
- `regwrite` output 1: register file write enable.
- `alusrca` output 1: ALU A select; 0=PC, 1=register A.
- `alusrcb` output 2: ALU B select; 00=B, 01=constant 4, 10=sign-extended immediate, 11=sign-extended immediate shifted left 2.
- `aluop` output 2: 00=add, 01=subtract, 10=funct-decoded.
- `pcsource` output 2: 00=ALU result, 01=ALUOut, 10=jump target.
- `illegal_op` output 1: one-cycle pulse when an opcode is unrecognised.
- `state` output 4: current state encoding, for debug.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, JUMP=9, ADDIEX=10, ADDIWB=11. Encodings 12–15 are unreachable; if entered, the next state is FETCH.
- Transitions:
  - FETCH→DECODE when mem_ready=1; otherwise stay in FETCH.
  - DECODE on opcode: 000000→EXEC; 100011 or 101011→MEMADR; 000100→BRANCH; 000010→JUMP; 001000→ADDIEX (only when enabled). Any other opcode→FETCH with illegal_op=1.
  - MEMADR: 100011→MEMRD; 101011→MEMWR.
  - MEMRD→MEMWB when mem_ready=1; otherwise stay.
  - MEMWR→FETCH when mem_ready=1; otherwise stay.
  - EXEC→ALUWB, ADDIEX→ADDIWB.
  - MEMWB, ALUWB, ADDIWB, BRANCH and JUMP all go to FETCH.
- Outputs are decoded from state. The only exception is that irwrite and pcwrite in FETCH are gated by mem_ready. Every output not listed for a state is 0.
  - FETCH: memread=1, alusrcb=01, irwrite=mem_ready, pcwrite=mem_ready.
  - DECODE: alusrcb=11.
  - MEMADR: alusrca=1, alusrcb=10.
  - MEMRD: memread=1, iord=1.
  - MEMWB: regwrite=1, memtoreg=1.
  - MEMWR: memwrite=1, iord=1.
  - EXEC: alusrca=1, aluop=10.
  - ALUWB: regwrite=1, regdist=1.
  - BRANCH: alusrca=1, aluop=01, pcwritecond=1, pcsource=01.
  - JUMP: pcwrite=1, pcsource=10.
  - ADDIEX: alusrca=1, alusrcb=10.
  - ADDIWB: regwrite=1.
- memread and memwrite stay asserted for every wait cycle of a stalled access. regwrite, pcwrite and pcwritecond are never asserted during a wait cycle.

## Timing
- State register only; outputs are combinational from state (plus mem_ready in FETCH). There are no output registers.
- Reset (async assert, released on a clock edge) puts state in FETCH. While in reset, outputs show FETCH values: memread=1, alusrcb=01, irwrite=pcwrite=mem_ready, all others 0. illegal_op=0.
- Cycles per instruction with mem_ready held high: R-type 4, LW 5, SW 4, BEQ 3, J 3, ADDI 4. Each low mem_ready cycle in FETCH, MEMRD or MEMWR adds 1 cycle.
- Reset asserted mid-instruction aborts it immediately. Writes already committed are not undone. The FSM does not finish the instruction.

## Configuration
- `MCFSM_ADDI_EN` defined: opcode 001000 decodes to ADDIEX→ADDIWB, executing rt = rs + sign-extended immediate.
- `MCFSM_ADDI_EN` undefined: opcode 001000 is illegal (DECODE→FETCH, illegal_op pulse), and states 10/11 are unreachable and treated as unused encodings.

## Test plan
- Assert reset with mem_ready=1, then release → state=0, memread=1, alusrcb=01, irwrite=1, pcwrite=1; next cycle state=1.
- R-type (opcode 000000) with mem_ready=1 → states 0,1,6,7,0; regwrite=1 and regdist=1 only in state 7.
- LW (100011) with mem_ready low for 2 cycles in MEMRD → states 0,1,2,3,3,3,4,0; iord=1 and memread=1 throughout state 3; regwrite=1 and memtoreg=1 in state 4.
- SW then BEQ then J → SW: 0,1,2,5,0 with memwrite=1 in state 5. BEQ: 0,1,8 with pcwritecond=1, aluop=01. J: 0,1,9 with pcwrite=1, pcsource=10.
- Opcode 111111 in DECODE → illegal_op=1 for exactly one cycle; next state=0; no regwrite or memwrite asserted.
- Reset asserted during MEMWR → state=0 asynchronously and memwrite drops immediately. With MCFSM_ADDI_EN defined, opcode 001000 runs 0,1,10,11; without it, illegal_op pulses.
